bsw_debounce: RTL and testbench
===============================

Name: bsw_debounce

Overview:
- Conditions the raw 6-bit BSW push-button bus before the LED effect logic uses it.
- Per channel, it synchronises, debounces, applies polarity and detects edges and long presses.
- Outputs are clean levels plus one-cycle event pulses, all in the SYS_CLK domain.
- Consumers use these pulses to select effects and speed, which sit directly downstream of this block.

Parameters:
- CLK_FREQ, 50_000_000, SYS_CLK frequency in Hz. Must be a multiple of 1000 and at least 1000.
- N, 6, number of button channels.
- DEBOUNCE_MS, 20, number of consecutive ms ticks the synced input must differ from state before state flips. Must be at least 1.
- LONG_MS, 1000, number of ms ticks of continuous pressed state before BTN_LONG fires. Must be greater than DEBOUNCE_MS.
- ACTIVE_LOW, 1, 1 means a raw 0 is pressed.

Ports:
- SYS_CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- BSW  in  N  raw asynchronous button inputs
- BTN_STATE  out  N  debounced level, 1 = pressed
- BTN_PRESS  out  N  one-cycle pulse on debounced 0->1
- BTN_RELEASE  out  N  one-cycle pulse on debounced 1->0
- BTN_LONG  out  N  one-cycle pulse when pressed continuously for LONG_MS ticks
- MS_TICK  out  1  one-cycle pulse every CLK_FREQ/1000 cycles

Behaviour:
- Reset: the single clock is SYS_CLK; reset is asynchronous and active-high (RESET).
  - All flops clear immediately on RESET=1.
  - Sync stages load the "not pressed" value after polarity.
  - All outputs read 0 during reset and in the first cycle after release.
- Prescaler:
  - Counter of width $clog2(CLK_FREQ/1000) counts 0..CLK_FREQ/1000-1, then wraps.
  - MS_TICK=1 in the cycle the counter equals its maximum.
  - The first tick comes CLK_FREQ/1000 cycles after reset release.
- Sync:
  - Two-flop synchroniser per bit.
  - Polarity is applied after the second flop: pressed = ACTIVE_LOW ? ~s2 : s2.
- Debounce, per channel:
  - db_cnt, width $clog2(DEBOUNCE_MS+1), cleared in any cycle where pressed == state.
  - While pressed != state, db_cnt increments on each MS_TICK.
  - If MS_TICK occurs and db_cnt == DEBOUNCE_MS-1: state toggles and db_cnt clears.
  - Any single-cycle agreement between pressed and state restarts the count.
  - Debounce latency is 2 sync cycles, plus DEBOUNCE_MS ticks of stable input. The first tick may be partial, so real latency is DEBOUNCE_MS-1 to DEBOUNCE_MS ms.
- Edges:
  - state_prev is a one-cycle delay of state.
  - BTN_PRESS = state & ~state_prev; BTN_RELEASE = ~state & state_prev.
  - Each pulse is coincident with the first cycle of the new BTN_STATE level.
- Long press, per channel:
  - hold_cnt, width $clog2(LONG_MS+1), saturating.
  - Cleared whenever state=0.
  - While state=1, increments on MS_TICK until it equals LONG_MS.
  - BTN_LONG=1 for the single cycle in which hold_cnt transitions LONG_MS-1 -> LONG_MS.
  - Fires exactly once per press, with no repeat.
  - Release after a long press still emits BTN_RELEASE.
- Boundaries:
  - Channels are fully independent. Simultaneous events on several channels give pulses in the same cycle.
  - A release within the same tick that completes the press is impossible by construction, since state changes only on MS_TICK.
  - RESET mid-press clears state with no BTN_RELEASE pulse. A still-held button re-debounces after reset and yields a new BTN_PRESS.

Decomposition:
- Package board_pkg:
  - localparam MS_PER_SEC=1000.
  - Helper function ms_to_cycles(clk_freq).
  - Shared default constants DEBOUNCE_MS_DEF=20 and LONG_MS_DEF=1000.
- Sub-module debounce_channel, instantiated N times in a generate loop.
  - Contains the sync flops, db_cnt, state, state_prev and hold_cnt.
  - Its inputs are the raw bit, MS_TICK and the polarity/timing parameters.
- The prescaler lives in bsw_debounce so a single MS_TICK is shared by all channels.

Test Plan (CLK_FREQ=10_000 giving a tick every 10 cycles, DEBOUNCE_MS=4, LONG_MS=20, ACTIVE_LOW=1):
1. Reset: RESET=1 with BSW=6'h3F → all outputs 0. After release, MS_TICK pulses at cycles 10, 20, 30…, and all BTN_* stay 0 for 200 cycles.
2. Clean press: BSW[0]=0 held from cycle 100 → BTN_STATE[0] rises 3–4 ticks after sync (about cycle 140). BTN_PRESS[0] is high exactly 1 cycle and coincides with the rise; other bits stay 0.
3. Bounce: BSW[1] toggles every 15 cycles for 120 cycles, then is held 0 → no BTN_PRESS[1] during bouncing. Exactly one BTN_PRESS[1] follows once 4 ticks of stability have elapsed.
4. Long press: BSW[2] held 0 for 30 ms then released → BTN_LONG[2] fires once, on the 20th tick after BTN_STATE[2] rose. BTN_RELEASE[2] fires once after the debounce delay following release, with no second BTN_LONG.
5. Simultaneous: BSW[3] and BSW[5] drop in the same cycle → BTN_PRESS[3] and BTN_PRESS[5] are asserted in the same cycle.
6. Reset mid-operation: BSW[4] held with BTN_STATE[4]=1 and hold_cnt=10, then RESET is pulsed for 3 cycles → outputs go to 0 immediately with no release pulse. With the button still held, BTN_PRESS[4] reappears after re-debounce, and BTN_LONG[4] comes 20 ticks after that.

Source files
------------

// File: rtl/board_pkg.sv
// Shared board-level constants and helpers for the button conditioning path.
package board_pkg;

    localparam int MS_PER_SEC      = 1000;
    localparam int DEBOUNCE_MS_DEF = 20;
    localparam int LONG_MS_DEF     = 1000;

    // Number of clock cycles in one millisecond at the given clock frequency.
    function automatic int ms_to_cycles(input int clk_freq);
        return clk_freq / MS_PER_SEC;
    endfunction

endpackage

// File: rtl/bsw_debounce_if.sv
// Button bus: raw inputs in, clean levels and event pulses out.
interface bsw_debounce_if #(
    parameter int N = 6
);

    logic [N-1:0] BSW;
    logic [N-1:0] BTN_STATE;
    logic [N-1:0] BTN_PRESS;
    logic [N-1:0] BTN_RELEASE;
    logic [N-1:0] BTN_LONG;
    logic         MS_TICK;

    // Producer of raw buttons / consumer of events.
    modport master (
        output BSW,
        input  BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_LONG, MS_TICK
    );

    // The conditioning block itself.
    modport slave (
        input  BSW,
        output BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_LONG, MS_TICK
    );

endinterface

// File: rtl/debounce_channel.sv
// One button channel: 2-flop sync, polarity, ms-tick debounce, edge and
// long-press detection. State only moves on ms_tick, so a press and its
// release can never complete within the same tick.
module debounce_channel
    import board_pkg::*;
#(
    parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF,
    parameter int LONG_MS     = LONG_MS_DEF,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic ms_tick,
    output logic btn_state,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam int DB_W   = $clog2(DEBOUNCE_MS + 1);
    localparam int HOLD_W = $clog2(LONG_MS + 1);

    // Raw level that means "not pressed"; sync flops reset to it.
    localparam logic              IDLE_RAW = ACTIVE_LOW;
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_MS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_MS);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_MS - 1);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              state_q, state_d;
    logic              state_prev_q, state_prev_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              pressed;

    assign pressed = ACTIVE_LOW ? ~sync2_q : sync2_q;

    // Next-state: sync shift, debounce counter/state, saturating hold counter.
    always_comb begin
        sync1_d      = raw;
        sync2_d      = sync1_q;
        state_prev_d = state_q;
        state_d      = state_q;
        db_cnt_d     = '0;
        if (pressed != state_q) begin
            db_cnt_d = db_cnt_q;
            if (ms_tick) begin
                if (db_cnt_q == DB_LAST) begin
                    state_d  = ~state_q;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
        end
        hold_cnt_d = hold_cnt_q;
        if (!state_q)
            hold_cnt_d = '0;
        else if (ms_tick && hold_cnt_q != HOLD_MAX)
            hold_cnt_d = hold_cnt_q + 1'b1;
    end

    // Channel registers, cleared to the idle condition on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= IDLE_RAW;
            sync2_q      <= IDLE_RAW;
            db_cnt_q     <= '0;
            state_q      <= 1'b0;
            state_prev_q <= 1'b0;
            hold_cnt_q   <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            db_cnt_q     <= db_cnt_d;
            state_q      <= state_d;
            state_prev_q <= state_prev_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    assign btn_state   = state_q;
    assign btn_press   = state_q & ~state_prev_q;
    assign btn_release = ~state_q & state_prev_q;
    // Fires on the LONG_MS-1 -> LONG_MS step; saturation prevents repeats.
    assign btn_long    = state_q & ms_tick & (hold_cnt_q == HOLD_PRE);

endmodule

// File: rtl/bsw_debounce.sv
// BSW button conditioner: shared ms prescaler feeding N independent channels.
module bsw_debounce
    import board_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int N           = 6,
    parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF,
    parameter int LONG_MS     = LONG_MS_DEF,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input logic             SYS_CLK,
    input logic             RESET,
    bsw_debounce_if.slave   bus
);

    localparam int            PRESC     = ms_to_cycles(CLK_FREQ);
    localparam int            PW        = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          ms_tick;
    logic [N-1:0]  st, pr, rl, lg;

    assign ms_tick = (presc_q == PRESC_MAX);

    // Prescaler wraps at its maximum, giving one tick per millisecond.
    always_comb begin
        presc_d = ms_tick ? '0 : presc_q + 1'b1;
    end

    // Prescaler register.
    always_ff @(posedge SYS_CLK or posedge RESET) begin
        if (RESET) presc_q <= '0;
        else       presc_q <= presc_d;
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_MS (DEBOUNCE_MS),
            .LONG_MS     (LONG_MS),
            .ACTIVE_LOW  (ACTIVE_LOW)
        ) u_ch (
            .clk         (SYS_CLK),
            .rst         (RESET),
            .raw         (bus.BSW[i]),
            .ms_tick     (ms_tick),
            .btn_state   (st[i]),
            .btn_press   (pr[i]),
            .btn_release (rl[i]),
            .btn_long    (lg[i])
        );
    end

    assign bus.BTN_STATE   = st;
    assign bus.BTN_PRESS   = pr;
    assign bus.BTN_RELEASE = rl;
    assign bus.BTN_LONG    = lg;
    assign bus.MS_TICK     = ms_tick;

endmodule

// File: tb/tb_bsw_debounce.sv
// Directed bench for bsw_debounce: tick every 10 cycles, 4 ms debounce,
// 20 ms long press, active-low buttons. t counts clock edges since the
// last reset release; outputs are sampled 1 time unit after each edge.
module tb_bsw_debounce;

    localparam int N        = 6;
    localparam int CLK_FREQ = 10_000;
    localparam int TP       = CLK_FREQ / 1000;
    localparam int DB       = 4;
    localparam int LONG     = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bsw_debounce_if #(.N(N)) bus ();

    bsw_debounce #(
        .CLK_FREQ(CLK_FREQ), .N(N), .DEBOUNCE_MS(DB), .LONG_MS(LONG), .ACTIVE_LOW(1'b1)
    ) dut (
        .SYS_CLK (clk),
        .RESET   (rst),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int t     = 0;
    int press_cnt[N], press_at[N], rel_cnt[N], rel_at[N], long_cnt[N], long_at[N];

    // Interval t carries a tick when t%TP == TP-1 (first tick: 10th cycle).
    function automatic int first_tick(input int x);
        return x + ((TP - 1) - (x % TP));
    endfunction

    // Input changed right after edge x: 2 sync edges, then DB ticks of
    // stability; the new level is visible after the edge following tick DB.
    function automatic int exp_edge(input int x);
        return first_tick(x + 2) + (DB - 1) * TP + 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    // Advance n cycles, recording pulse counts and last pulse cycle per channel.
    task automatic watch(input int n);
        for (int c = 0; c < N; c++) begin
            press_cnt[c] = 0; press_at[c] = -1; rel_cnt[c] = 0;
            rel_at[c] = -1; long_cnt[c] = 0; long_at[c] = -1;
        end
        for (int k = 0; k < n; k++) begin
            step();
            for (int c = 0; c < N; c++) begin
                if (bus.BTN_PRESS[c])   begin press_cnt[c]++; press_at[c] = t; end
                if (bus.BTN_RELEASE[c]) begin rel_cnt[c]++;   rel_at[c]   = t; end
                if (bus.BTN_LONG[c])    begin long_cnt[c]++;  long_at[c]  = t; end
            end
        end
    endtask

    task automatic test_reset();
        logic [4*N:0] outs;
        bus.BSW = 6'h3F;
        rst     = 1'b1;
        repeat (3) step();
        outs = {bus.BTN_STATE, bus.BTN_PRESS, bus.BTN_RELEASE, bus.BTN_LONG, bus.MS_TICK};
        n_vec++;
        if (outs !== '0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", outs); end
        rst = 1'b0;
        t   = 0;
        outs = {bus.BTN_STATE, bus.BTN_PRESS, bus.BTN_RELEASE, bus.BTN_LONG, bus.MS_TICK};
        n_vec++;
        if (outs !== '0) begin n_err++; $display("FAIL post_release_outputs: got %h want 0", outs); end
        for (int k = 0; k < 200; k++) begin
            step();
            n_vec++;
            if (bus.MS_TICK !== (t % TP == TP - 1)) begin
                n_err++;
                $display("FAIL ms_tick t=%0d: got %b want %b", t, bus.MS_TICK, (t % TP == TP - 1));
            end
            outs = {bus.BTN_STATE, bus.BTN_PRESS, bus.BTN_RELEASE, bus.BTN_LONG, 1'b0};
            n_vec++;
            if (outs !== '0) begin n_err++; $display("FAIL idle_btn t=%0d: got %h want 0", t, outs); end
        end
    endtask

    task automatic test_clean_press();
        int exp_r, exp_f;
        exp_r = exp_edge(t);
        bus.BSW[0] = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (bus.BTN_STATE[0]) break;
        end
        n_vec++;
        if (t !== exp_r) begin n_err++; $display("FAIL press_rise_cycle: got %0d want %0d", t, exp_r); end
        n_vec++;
        if (bus.BTN_PRESS !== 6'h01) begin n_err++; $display("FAIL press_pulse: got %h want 01", bus.BTN_PRESS); end
        n_vec++;
        if (bus.BTN_STATE !== 6'h01) begin n_err++; $display("FAIL press_state: got %h want 01", bus.BTN_STATE); end
        step();
        n_vec++;
        if (bus.BTN_PRESS !== 6'h00) begin n_err++; $display("FAIL press_one_cycle: got %h want 00", bus.BTN_PRESS); end
        exp_f = exp_edge(t);
        bus.BSW[0] = 1'b1;
        watch(60);
        n_vec++;
        if (rel_cnt[0] !== 1 || rel_at[0] !== exp_f) begin
            n_err++; $display("FAIL release0: got %0d pulses at %0d want 1 at %0d", rel_cnt[0], rel_at[0], exp_f);
        end
        n_vec++;
        if (bus.BTN_STATE !== 6'h00) begin n_err++; $display("FAIL release0_state: got %h want 00", bus.BTN_STATE); end
    endtask

    task automatic test_bounce();
        int exp_r, exp_f;
        for (int seg = 0; seg < 8; seg++) begin
            bus.BSW[1] = seg[0];
            watch(15);
            n_vec++;
            if (press_cnt[1] !== 0) begin n_err++; $display("FAIL bounce_seg%0d: got %0d presses want 0", seg, press_cnt[1]); end
        end
        exp_r = exp_edge(t);
        bus.BSW[1] = 1'b0;
        watch(60);
        n_vec++;
        if (press_cnt[1] !== 1 || press_at[1] !== exp_r) begin
            n_err++; $display("FAIL bounce_settle: got %0d presses at %0d want 1 at %0d", press_cnt[1], press_at[1], exp_r);
        end
        exp_f = exp_edge(t);
        bus.BSW[1] = 1'b1;
        watch(60);
        n_vec++;
        if (rel_cnt[1] !== 1 || rel_at[1] !== exp_f) begin
            n_err++; $display("FAIL bounce_release: got %0d pulses at %0d want 1 at %0d", rel_cnt[1], rel_at[1], exp_f);
        end
    endtask

    task automatic test_long_press();
        int exp_r, exp_l, exp_f;
        exp_r = exp_edge(t);
        exp_l = exp_r + LONG * TP - 1;
        bus.BSW[2] = 1'b0;
        watch(30 * TP);
        n_vec++;
        if (press_cnt[2] !== 1 || press_at[2] !== exp_r) begin
            n_err++; $display("FAIL long_press_rise: got %0d at %0d want 1 at %0d", press_cnt[2], press_at[2], exp_r);
        end
        n_vec++;
        if (long_cnt[2] !== 1 || long_at[2] !== exp_l) begin
            n_err++; $display("FAIL long_pulse: got %0d at %0d want 1 at %0d", long_cnt[2], long_at[2], exp_l);
        end
        exp_f = exp_edge(t);
        bus.BSW[2] = 1'b1;
        watch(100);
        n_vec++;
        if (rel_cnt[2] !== 1 || rel_at[2] !== exp_f) begin
            n_err++; $display("FAIL long_release: got %0d at %0d want 1 at %0d", rel_cnt[2], rel_at[2], exp_f);
        end
        n_vec++;
        if (long_cnt[2] !== 0) begin n_err++; $display("FAIL long_repeat: got %0d want 0", long_cnt[2]); end
    endtask

    task automatic test_simultaneous();
        int exp_r, exp_f;
        exp_r = exp_edge(t);
        bus.BSW[3] = 1'b0;
        bus.BSW[5] = 1'b0;
        watch(60);
        n_vec++;
        if (press_at[3] !== exp_r || press_at[5] !== exp_r || press_cnt[3] !== 1 || press_cnt[5] !== 1) begin
            n_err++; $display("FAIL simul_press: got %0d/%0d want %0d", press_at[3], press_at[5], exp_r);
        end
        n_vec++;
        if (press_cnt[4] !== 0) begin n_err++; $display("FAIL simul_other: got %0d want 0", press_cnt[4]); end
        exp_f = exp_edge(t);
        bus.BSW[3] = 1'b1;
        bus.BSW[5] = 1'b1;
        watch(60);
        n_vec++;
        if (rel_at[3] !== exp_f || rel_at[5] !== exp_f || rel_cnt[3] !== 1 || rel_cnt[5] !== 1) begin
            n_err++; $display("FAIL simul_release: got %0d/%0d want %0d", rel_at[3], rel_at[5], exp_f);
        end
    endtask

    task automatic test_reset_mid();
        int exp_r;
        logic [4*N:0] outs;
        exp_r = exp_edge(t);
        bus.BSW[4] = 1'b0;
        // Hold until 10 ticks after the rise, so the hold counter sits at 10.
        watch(exp_r - t + 10 * TP);
        n_vec++;
        if (bus.BTN_STATE !== 6'h10 || press_at[4] !== exp_r) begin
            n_err++; $display("FAIL mid_pre_state: got %h at %0d want 10 at %0d", bus.BTN_STATE, press_at[4], exp_r);
        end
        rst = 1'b1;
        #1;
        outs = {bus.BTN_STATE, bus.BTN_PRESS, bus.BTN_RELEASE, bus.BTN_LONG, bus.MS_TICK};
        n_vec++;
        if (outs !== '0) begin n_err++; $display("FAIL mid_async_clear: got %h want 0", outs); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            outs = {bus.BTN_STATE, bus.BTN_PRESS, bus.BTN_RELEASE, bus.BTN_LONG, bus.MS_TICK};
            n_vec++;
            if (outs !== '0) begin n_err++; $display("FAIL mid_in_reset%0d: got %h want 0", k, outs); end
        end
        rst = 1'b0;
        t   = 0;
        watch(300);
        exp_r = exp_edge(0);
        n_vec++;
        if (press_cnt[4] !== 1 || press_at[4] !== exp_r) begin
            n_err++; $display("FAIL mid_repress: got %0d at %0d want 1 at %0d", press_cnt[4], press_at[4], exp_r);
        end
        n_vec++;
        if (long_cnt[4] !== 1 || long_at[4] !== exp_r + LONG * TP - 1) begin
            n_err++; $display("FAIL mid_long: got %0d at %0d want 1 at %0d", long_cnt[4], long_at[4], exp_r + LONG * TP - 1);
        end
        n_vec++;
        if (rel_cnt[4] !== 0) begin n_err++; $display("FAIL mid_no_release: got %0d want 0", rel_cnt[4]); end
    endtask

    initial begin
        bus.BSW = 6'h3F;
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_simultaneous();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
